// File: rtl/alu_cmd_driver_if.sv
// Signal bundle between a command source / response sink / ALU and alu_cmd_driver.
// The driver block connects through the slave modport; the surrounding environment uses master.
interface alu_cmd_driver_if;
  // Both streams use valid/ready: a transfer happens on a rising edge where valid && ready.
  // The producer holds its payload stable while valid && !ready, and ready may not depend on the transfer itself.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_opcode;
  logic [3:0] cmd_op1;
  logic [3:0] cmd_op2;

  logic [1:0] alu_opcode;
  logic [3:0] alu_operand1;
  logic [3:0] alu_operand2;
  logic [7:0] alu_result;
  logic       alu_cflag;
  logic       alu_zflag;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_opcode;
  logic [7:0] rsp_result;
  logic       rsp_cflag;
  logic       rsp_zflag;

  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2,
    input  cmd_ready,
    input  alu_opcode, alu_operand1, alu_operand2,
    output alu_result, alu_cflag, alu_zflag,
    input  rsp_valid, rsp_opcode, rsp_result, rsp_cflag, rsp_zflag,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2,
    output cmd_ready,
    output alu_opcode, alu_operand1, alu_operand2,
    input  alu_result, alu_cflag, alu_zflag,
    output rsp_valid, rsp_opcode, rsp_result, rsp_cflag, rsp_zflag,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Buffers ALU commands in a small FIFO, issues them one at a time on registered
// operand/opcode lines and returns the captured ALU result as an in-order response stream.
module alu_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.slave  bus,
  output logic [CW-1:0]    cmd_count,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef logic [9:0] entry_t;  // {opcode, op1, op2}

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    alu_opcode_q, alu_opcode_d;
  logic [3:0]    alu_op1_q, alu_op1_d;
  logic [3:0]    alu_op2_q, alu_op2_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_opcode_q, rsp_opcode_d;
  logic [7:0]    rsp_result_q, rsp_result_d;
  logic          rsp_cflag_q, rsp_cflag_d;
  logic          rsp_zflag_q, rsp_zflag_d;

  logic          full;
  logic          empty;
  logic          cmd_ready_w;
  logic          push;
  logic          pop;
  logic          capture;
  logic          rsp_fire;
  entry_t        head;

  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  // Full blocks the push even when the FSM pops on the same edge.
  assign cmd_ready_w = !full && rst_n;
  assign push        = bus.cmd_valid && cmd_ready_w;
  assign rsp_fire    = rsp_valid_q && bus.rsp_ready;
  assign head        = mem_q[rd_ptr_q];

  // Next-state logic; FIFO occupancy is the pre-edge value, so a push on this edge is seen next cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_fire) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.cmd_opcode, bus.cmd_op1, bus.cmd_op2};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Operand lines keep the last issued command after it completes.
  always_comb begin
    alu_opcode_d = alu_opcode_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    if (pop) begin
      {alu_opcode_d, alu_op1_d, alu_op2_d} = head;
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_opcode_d = rsp_opcode_q;
    rsp_result_d = rsp_result_q;
    rsp_cflag_d  = rsp_cflag_q;
    rsp_zflag_d  = rsp_zflag_q;
    if (rsp_fire) begin
      rsp_valid_d = 1'b0;
    end
    if (capture) begin
      rsp_valid_d  = 1'b1;
      rsp_opcode_d = alu_opcode_q;
      rsp_result_d = bus.alu_result;
      rsp_cflag_d  = bus.alu_cflag;
      rsp_zflag_d  = bus.alu_zflag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_opcode_q <= '0;
      rsp_result_q <= '0;
      rsp_cflag_q  <= 1'b0;
      rsp_zflag_q  <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_opcode_q <= rsp_opcode_d;
      rsp_result_q <= rsp_result_d;
      rsp_cflag_q  <= rsp_cflag_d;
      rsp_zflag_q  <= rsp_zflag_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_w;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_operand1 = alu_op1_q;
  assign bus.alu_operand2 = alu_op2_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_opcode   = rsp_opcode_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_cflag    = rsp_cflag_q;
  assign bus.rsp_zflag    = rsp_zflag_q;
  assign cmd_count        = count_q;
  assign busy             = (state_q != S_IDLE);
  assign dbg_state        = state_q;

  // A held response must not change until it is taken.
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q && !bus.rsp_ready) |=>
      (rsp_valid_q && $stable({rsp_opcode_q, rsp_result_q, rsp_cflag_q, rsp_zflag_q})));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_FULL);

  a_exec_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_EXEC) |=> (state_q == S_RESP));

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: behavioural ALU, in-order response scoreboard,
// cycle-exact latency checks, backpressure, pointer wrap and mid-operation reset.
module tb_alu_cmd_driver;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cmd_count;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [7:0]    alu_res;

  alu_cmd_driver_if bus ();

  alu_cmd_driver #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cmd_count (cmd_count),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural model of the existing combinational ALU.
  always_comb begin
    alu_res = 8'd0;
    case (bus.alu_opcode)
      2'b00: alu_res = {4'd0, bus.alu_operand1} + {4'd0, bus.alu_operand2};
      2'b01: alu_res = {4'd0, bus.alu_operand1} * {4'd0, bus.alu_operand2};
      2'b10: alu_res = {4'd0, bus.alu_operand1 | bus.alu_operand2};
      2'b11: alu_res = {4'd0, bus.alu_operand1 & bus.alu_operand2};
      default: alu_res = 8'd0;
    endcase
  end
  assign bus.alu_result = alu_res;
  assign bus.alu_cflag  = alu_res[4];
  assign bus.alu_zflag  = (alu_res == 8'd0);

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int hs_gap = 0;
  bit sent_done = 1'b0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pack(input logic [1:0] op, input logic [7:0] res);
    return {op, res, res[4], (res == 8'd0)};
  endfunction

  // Every response handshake is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_opcode", 32'(bus.rsp_opcode), 32'(mon_e[11:10]));
        check("rsp_result", 32'(bus.rsp_result), 32'(mon_e[9:2]));
        check("rsp_cflag",  32'(bus.rsp_cflag),  32'(mon_e[1]));
        check("rsp_zflag",  32'(bus.rsp_zflag),  32'(mon_e[0]));
      end
      hs_gap      = cyc - last_hs_cyc;
      last_hs_cyc = cyc;
    end
  end

  // Returns #1 after the edge on which the command was accepted.
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] res);
    bit acc;
    acc            = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_op1    = a;
    bus.cmd_op2    = b;
    exp_q.push_back(pack(op, res));
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy && !bus.rsp_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
    check({tag, "_alu_op1"}, 32'(bus.alu_operand1), 32'd0);
    check({tag, "_alu_op2"}, 32'(bus.alu_operand2), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_opcode"}, 32'(bus.rsp_opcode), 32'd0);
    check({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
    check({tag, "_rsp_cflag"}, 32'(bus.rsp_cflag), 32'd0);
    check({tag, "_rsp_zflag"}, 32'(bus.rsp_zflag), 32'd0);
    check({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Wrap-around vectors: opcode, operand1, operand2, hand-computed result.
  logic [1:0] w_op  [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [3:0] w_a   [10] = '{4'd7, 4'd4, 4'd0, 4'd15, 4'd9, 4'd15, 4'd3, 4'd5, 4'd15, 4'd7};
  logic [3:0] w_b   [10] = '{4'd8, 4'd4, 4'd0, 4'd9, 4'd9, 4'd2, 4'd12, 4'd10, 4'd1, 4'd9};
  logic [7:0] w_res [10] = '{8'd15, 8'd16, 8'd0, 8'd9, 8'd18, 8'd30, 8'd15, 8'd0, 8'd16, 8'd63};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 2'd0;
    bus.cmd_op1    = 4'd0;
    bus.cmd_op2    = 4'd0;
    bus.rsp_ready  = 1'b0;
    rst_n          = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("cmd_ready_out_of_rst", 32'(bus.cmd_ready), 32'd1);

    // Single ADD with exact latency
    bus.rsp_ready = 1'b1;
    send(2'd0, 4'd4, 4'd5, 8'd9);
    check("t1_count_after_accept", 32'(cmd_count), 32'd1);
    check("t1_busy_after_accept", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("t1_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    check("t1_alu_op1", 32'(bus.alu_operand1), 32'd4);
    check("t1_alu_op2", 32'(bus.alu_operand2), 32'd5);
    check("t1_state_exec", 32'(dbg_state), 32'd1);
    check("t1_rsp_valid_low", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_rsp_valid_high", 32'(bus.rsp_valid), 32'd1);
    check("t1_rsp_result", 32'(bus.rsp_result), 32'd9);
    @(posedge clk);
    #1;
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_rsp_valid_clear", 32'(bus.rsp_valid), 32'd0);
    check("t1_alu_op1_held", 32'(bus.alu_operand1), 32'd4);

    // Back-to-back: carry then zero, one response every 2 cycles
    send(2'd0, 4'd12, 4'd5, 8'd17);
    send(2'd0, 4'd0, 4'd0, 8'd0);
    wait_idle();
    check("t2_rsp_gap", 32'(hs_gap), 32'd2);

    // MUL / AND / OR
    send(2'd1, 4'd15, 4'd15, 8'd225);
    send(2'd3, 4'd2, 4'd6, 8'd2);
    send(2'd2, 4'd8, 4'd1, 8'd9);
    wait_idle();

    // Backpressure: one held in RESP, four filling the FIFO, sixth blocked
    bus.rsp_ready = 1'b0;
    send(2'd0, 4'd1, 4'd2, 8'd3);
    send(2'd1, 4'd3, 4'd5, 8'd15);
    send(2'd2, 4'd5, 4'd10, 8'd15);
    send(2'd3, 4'd12, 4'd10, 8'd8);
    send(2'd0, 4'd15, 4'd15, 8'd30);
    check("t4_count_full", 32'(cmd_count), 32'd4);
    check("t4_cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
    check("t4_state_resp", 32'(dbg_state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("t4_hold_result", 32'(bus.rsp_result), 32'd3);
      check("t4_hold_count", 32'(cmd_count), 32'd4);
    end
    bus.rsp_ready = 1'b1;
    send(2'd1, 4'd0, 4'd7, 8'd0);
    wait_idle();

    // Pointer wrap with alternating rsp_ready
    sent_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(w_op[i], w_a[i], w_b[i], w_res[i]);
        sent_done = 1'b1;
      end
      begin
        for (int i = 0; i < 400; i++) begin
          if (sent_done && exp_q.size() == 0) break;
          @(posedge clk);
          #1;
          bus.rsp_ready = ~bus.rsp_ready;
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_idle();

    // Reset while in EXEC with two commands queued
    bus.rsp_ready = 1'b0;
    send(2'd0, 4'd2, 4'd3, 8'd5);
    send(2'd1, 4'd3, 4'd3, 8'd9);
    send(2'd2, 4'd1, 4'd2, 8'd3);
    bus.rsp_ready = 1'b1;
    send(2'd3, 4'd7, 4'd7, 8'd7);
    check("t6_state_exec", 32'(dbg_state), 32'd1);
    check("t6_count_two", 32'(cmd_count), 32'd2);
    check("t6_first_rsp_taken", 32'(exp_q.size()), 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("t6_rst");
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("t6_no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    send(2'd0, 4'd1, 4'd1, 8'd2);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
